multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the multicycle MIPS datapath. A Moore state machine decodes the instruction opcode and drives the select lines of the datapath multiplexers (ALU A/B sources, register-destination select, write-back select, PC source) together with the memory, IR, register-file and PC write strobes. Memory accesses use a ready handshake, so the FSM holds in a memory state until the memory responds.

## Interface
Parameters:
- none; opcodes and encodings come from the shared package

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- opcode  input  6  instr[31:26] from the IR; sampled only in DECODE
- zero  input  1  ALU zero flag; used only in BRANCH
- mem_ready  input  1  memory completes the current read/write this cycle
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- i_or_d  output  1  address mux: 0 = PC, 1 = ALUOut
- ir_write  output  1  IR load enable
- reg_write  output  1  register-file write enable
- reg_dst  output  1  write-register mux: 1 = rd, 0 = rt
- mem_to_reg  output  1  write-back mux: 1 = MDR, 0 = ALUOut
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  output  1  PC load enable, already combined with branch/zero
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- state  output  4  current state, for debug

## Operation
- Opcodes: R = 0x00, LW = 0x23, SW = 0x2B, BEQ = 0x04, J = 0x02, ADDI = 0x08.
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11
- Transitions:
  - FETCH→DECODE when mem_ready; otherwise stay in FETCH.
  - DECODE: LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX; any other opcode→FETCH with illegal_op pulsed.
  - MEMADR→MEMRD for LW, →MEMWR for SW. The opcode is latched in DECODE; the IR is not re-read.
  - MEMRD→MEMWB when mem_ready, else hold.
  - MEMWR→FETCH when mem_ready, else hold.
  - EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP→FETCH.
- Outputs per state; every signal not listed is 0:
  - FETCH: mem_read=1, alu_src_b=01. ir_write and pc_en are 1 only in the cycle mem_ready=1.
  - DECODE: alu_src_b=11 (branch target precompute).
  - MEMADR: alu_src_a=1, alu_src_b=10.
  - MEMRD: mem_read=1, i_or_d=1.
  - MEMWR: mem_write=1, i_or_d=1; instr_done=1 when mem_ready.
  - MEMWB: reg_write=1, mem_to_reg=1, instr_done=1.
  - EXEC: alu_src_a=1, alu_op=10.
  - ALUWB: reg_write=1, reg_dst=1, instr_done=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_en=zero, instr_done=1.
  - JUMP: pc_source=10, pc_en=1, instr_done=1.
  - ADDIEX: alu_src_a=1, alu_src_b=10.
  - ADDIWB: reg_write=1, instr_done=1.
- Every strobe (mem_read, mem_write, ir_write, reg_write, pc_en) is asserted only from a state decode. There is never a write strobe outside its state.

## Timing
- The state register updates on the rising edge of clk. Outputs are a combinational decode of the state, plus mem_ready/zero where noted above.
- Reset: state=FETCH.
  - While rst_n=0, every output is 0, including mem_read; state reads 0.
  - First fetch: mem_read=1 in the cycle after rst_n rises.
- Reset mid-instruction, including during a memory wait: the next state is FETCH; in-flight strobes drop in the same cycle as rst_n=0.
- Latency with zero-wait memory:
  - LW = 5 cycles, SW = 4, R = 4, ADDI = 4, BEQ = 3, J = 3.
  - Each cycle of mem_ready=0 adds one cycle.
- mem_ready while not in FETCH/MEMRD/MEMWR is ignored.
- zero outside BRANCH is ignored.
- illegal_op and DECODE→FETCH occur in the same cycle.

## Configuration
- MC_ADDI_EN defined: ADDIEX and ADDIWB exist; ADDI executes as specified above.
- MC_ADDI_EN undefined: the ADDI states are removed and opcode 0x08 is illegal (illegal_op pulse, return to FETCH). State encodings 10 and 11 are unused; if reached, the next state is FETCH.

## Structure
- Package mc_pkg:
  - opcode localparams
  - state enum (4-bit)
  - alu_op, alu_src_b and pc_source encodings
- One sub-module, mc_output_decode: a purely combinational state→control-word map. The top holds the state register, opcode latch and next-state logic.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 → all outputs 0. Release → FETCH, mem_read=1, ir_write=1, pc_en=1.
- LW (0x23), mem_ready always 1 → state sequence 0,1,2,3,4; reg_write=1, mem_to_reg=1 in state 4; instr_done once; 5 cycles total.
- SW (0x2B) with mem_ready low for 2 cycles in MEMWR → mem_write=1 for 3 cycles and reg_write never asserted; instr_done on the cycle mem_ready=1.
- BEQ (0x04): zero=1 → pc_en=1, pc_source=01 in BRANCH. Repeat with zero=0 → pc_en=0.
- Opcode 0x3F → illegal_op pulses once and the next state is 0. Opcode 0x08 → 10,11 with MC_ADDI_EN; illegal without it.
- rst_n=0 asserted in MEMRD while mem_ready=0 → mem_read drops the same cycle; state=0 after the edge.

Source files
------------

// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : shared opcodes, state encoding and control-word types for the
//          multicycle MIPS main control unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       instr_done;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mc_output_decode.sv
// ============================================================================
// mc_output_decode : combinational state -> control-word map (Moore outputs,
//                    qualified by mem_ready / zero where the state needs it).
// Optional feature macro: MC_ADDI_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module mc_output_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_source  = PC_ALUOUT;
        ctrl.pc_en      = zero;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source  = PC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : main Moore control FSM for the multicycle MIPS datapath.
// Optional feature macro: MC_ADDI_EN (ADDI states). Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic       w_illegal;
  ctrl_t      w_ctrl;
  ctrl_t      w_ctrl_g;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode;
    end
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_next = S_ADDIEX;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      // Opcode comes from the latch; the IR may already hold something else.
      S_MEMADR: w_next = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
`ifdef MC_ADDI_EN
      S_ADDIEX: w_next = S_ADDIWB;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .state     (r_state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (w_ctrl)
  );

  // Strobes must fall in the very cycle reset is asserted, not one edge later.
  assign w_ctrl_g   = rst_n ? w_ctrl : '0;
  assign mem_read   = w_ctrl_g.mem_read;
  assign mem_write  = w_ctrl_g.mem_write;
  assign i_or_d     = w_ctrl_g.i_or_d;
  assign ir_write   = w_ctrl_g.ir_write;
  assign reg_write  = w_ctrl_g.reg_write;
  assign reg_dst    = w_ctrl_g.reg_dst;
  assign mem_to_reg = w_ctrl_g.mem_to_reg;
  assign alu_src_a  = w_ctrl_g.alu_src_a;
  assign alu_src_b  = w_ctrl_g.alu_src_b;
  assign alu_op     = w_ctrl_g.alu_op;
  assign pc_source  = w_ctrl_g.pc_source;
  assign pc_en      = w_ctrl_g.pc_en;
  assign instr_done = w_ctrl_g.instr_done;
  assign illegal_op = rst_n & w_illegal;
  assign state      = rst_n ? r_state : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control : directed self-checking bench for multicycle_control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, pc_en, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .pc_en      (pc_en),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Field order: mr mw iod irw rw rd m2r asa asb aop pcs pce done ill
  logic [17:0] obs;
  assign obs = {mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, pc_en,
                instr_done, illegal_op};

  function automatic logic [17:0] cw(input logic mr, mw, iod, irw, rw, rd, m2r,
                                     asa, input logic [1:0] asb, aop, pcs,
                                     input logic pce, done, ill);
    return {mr, mw, iod, irw, rw, rd, m2r, asa, asb, aop, pcs, pce, done, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are set ~1 ns after a rising edge; checks run 1 ns later, then advance.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] exp_cw);
    #1;
    check({tag, ".state"}, {28'd0, state}, {28'd0, st});
    check({tag, ".ctrl"}, {14'd0, obs}, {14'd0, exp_cw});
    @(posedge clk);
    #1;
  endtask

  logic [17:0] c_fetch, c_fetch_wait, c_decode, c_decode_ill, c_memadr, c_memrd;
  logic [17:0] c_memwb, c_memwr, c_memwr_done, c_exec, c_aluwb, c_br1, c_br0, c_jump;

  initial begin
    c_fetch      = cw(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0,0);
    c_fetch_wait = cw(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
    c_decode     = cw(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
    c_decode_ill = cw(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,1);
    c_memadr     = cw(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    c_memrd      = cw(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    c_memwb      = cw(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,1,0);
    c_memwr      = cw(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    c_memwr_done = cw(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0);
    c_exec       = cw(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
    c_aluwb      = cw(0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,1,0);
    c_br1        = cw(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,1,0);
    c_br0        = cw(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,1,0);
    c_jump       = cw(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,1,0);

    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h23;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc("reset", 4'd0, 18'd0);
    rst_n = 1'b1;

    // LW, zero-wait: 0,1,2,3,4 then back to FETCH
    cyc("lw.fetch", 4'd0, c_fetch);
    cyc("lw.decode", 4'd1, c_decode);
    opcode = 6'h00;
    cyc("lw.memadr", 4'd2, c_memadr);
    cyc("lw.memrd", 4'd3, c_memrd);
    cyc("lw.memwb", 4'd4, c_memwb);

    // FETCH waits on memory, then SW with a 2-cycle write wait
    opcode = 6'h2B; mem_ready = 1'b0;
    cyc("sw.fetchwait", 4'd0, c_fetch_wait);
    mem_ready = 1'b1;
    cyc("sw.fetch", 4'd0, c_fetch);
    cyc("sw.decode", 4'd1, c_decode);
    opcode = 6'h23;
    cyc("sw.memadr", 4'd2, c_memadr);
    mem_ready = 1'b0;
    cyc("sw.memwr0", 4'd5, c_memwr);
    cyc("sw.memwr1", 4'd5, c_memwr);
    mem_ready = 1'b1;
    cyc("sw.memwr2", 4'd5, c_memwr_done);

    // R-type, with zero high to show it is ignored outside BRANCH
    opcode = 6'h00; zero = 1'b1;
    cyc("r.fetch", 4'd0, c_fetch);
    cyc("r.decode", 4'd1, c_decode);
    cyc("r.exec", 4'd6, c_exec);
    cyc("r.aluwb", 4'd7, c_aluwb);

    opcode = 6'h04; zero = 1'b1;
    cyc("beq1.fetch", 4'd0, c_fetch);
    cyc("beq1.decode", 4'd1, c_decode);
    cyc("beq1.branch", 4'd8, c_br1);
    zero = 1'b0;
    cyc("beq0.fetch", 4'd0, c_fetch);
    cyc("beq0.decode", 4'd1, c_decode);
    cyc("beq0.branch", 4'd8, c_br0);

    opcode = 6'h02;
    cyc("j.fetch", 4'd0, c_fetch);
    cyc("j.decode", 4'd1, c_decode);
    cyc("j.jump", 4'd9, c_jump);

    opcode = 6'h3F;
    cyc("ill.fetch", 4'd0, c_fetch);
    cyc("ill.decode", 4'd1, c_decode_ill);

    opcode = 6'h08;
    cyc("addi.fetch", 4'd0, c_fetch);
`ifdef MC_ADDI_EN
    cyc("addi.decode", 4'd1, c_decode);
    cyc("addi.ex", 4'd10, cw(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0));
    cyc("addi.wb", 4'd11, cw(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,1,0));
`else
    cyc("addi.decode", 4'd1, c_decode_ill);
`endif

    // Reset asserted in MEMRD during a memory wait
    opcode = 6'h23;
    cyc("rstmid.fetch", 4'd0, c_fetch);
    cyc("rstmid.decode", 4'd1, c_decode);
    cyc("rstmid.memadr", 4'd2, c_memadr);
    mem_ready = 1'b0;
    cyc("rstmid.memrd", 4'd3, c_memrd);
    rst_n = 1'b0;
    cyc("rstmid.inrst", 4'd0, 18'd0);
    rst_n = 1'b1; mem_ready = 1'b1;
    cyc("rstmid.fetch2", 4'd0, c_fetch);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
